// File: rtl/mbist_pkg.sv
// March C- BIST definitions shared by the controller and its response checker.
// Holds the controller state enum, the 3-bit element encoding E0..E5, and
// per-element lookup functions:
//   - sweep direction
//   - ops per address
//   - read/write kind of each op
//   - background bit of each op
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // March C- elements:
  //   E0 up(w0)      E1 up(r0,w1)   E2 up(r1,w0)
  //   E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } elem_t;

  // 1 = address sweep runs CAPACITY..0.
  function automatic logic elem_down(input elem_t e);
    return (e == E3) || (e == E4);
  endfunction

  // Ops issued per address within the element.
  function automatic logic [1:0] elem_nops(input elem_t e);
    return ((e == E0) || (e == E5)) ? 2'd1 : 2'd2;
  endfunction

  // 1 = write.
  // In the two-op elements, op 0 is the read and op 1 the write.
  function automatic logic op_is_write(input elem_t e, input logic op);
    logic wr;
    case (e)
      E0:      wr = 1'b1;
      E5:      wr = 1'b0;
      default: wr = op;
    endcase
    return wr;
  endfunction

  // Background bit of the op: data written, or data expected on a read.
  function automatic logic op_value(input elem_t e, input logic op);
    logic v;
    case (e)
      E1, E3:  v = op;        // r0, w1
      E2, E4:  v = ~op;       // r1, w0
      default: v = 1'b0;      // w0 / r0
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mbist_resp_cmp.sv
// Read-response checker for the March controller.
// Every issued read enters a 2-stage shift register of
// {valid, expected, addr, elem}. This lines it up with mem_rdata two cycles
// later, where it is compared against the memory's answer.
// Ports:
//   clk, rst         clock, async active-high reset
//   clear            wipes status and pipeline when a new run is accepted
//   push             a read is issued this cycle
//   push_data        expected read data of that read
//   push_addr        address of that read
//   push_elem        March element of that read
//   rdata            memory read data
//   fail             sticky mismatch flag
//   fail_count       saturating mismatch count
//   first_fail_addr  address of the first mismatch
//   first_fail_elem  element of the first mismatch
//   first_fail_data  rdata of the first mismatch
module mbist_resp_cmp
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [2:0]            push_elem,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [2:0]            first_fail_elem,
  output logic [DATA_WIDTH-1:0] first_fail_data
);

  logic                  v1, v2;
  logic [DATA_WIDTH-1:0] d1, d2;
  logic [ADDR_WIDTH-1:0] a1, a2;
  logic [2:0]            e1, e2;
  logic                  mismatch;

  assign mismatch = v2 && (rdata != d2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; d1 <= '0; a1 <= '0; e1 <= '0;
      v2 <= 1'b0; d2 <= '0; a2 <= '0; e2 <= '0;
      fail            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      first_fail_elem <= '0;
      first_fail_data <= '0;
    end else if (clear) begin
      v1 <= 1'b0; d1 <= '0; a1 <= '0; e1 <= '0;
      v2 <= 1'b0; d2 <= '0; a2 <= '0; e2 <= '0;
      fail            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      first_fail_elem <= '0;
      first_fail_data <= '0;
    end else begin
      v1 <= push;
      d1 <= push_data;
      a1 <= push_addr;
      e1 <= push_elem;
      v2 <= v1;
      d2 <= d1;
      a2 <= a1;
      e2 <= e1;
      if (mismatch) begin
        fail <= 1'b1;
        if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
        // The sticky flag is still low only on the first mismatch of the run.
        if (!fail) begin
          first_fail_addr <= a2;
          first_fail_elem <= e2;
          first_fail_data <= rdata;
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller.
// It drives one memory op per cycle with no bubbles. The response checker
// compares returned read data against the expected background.
//
// Start/status contract:
//   - start is a one-cycle pulse.
//   - It is accepted only in IDLE or DONE; a pulse while busy is dropped.
//   - busy covers PREP..DRAIN.
//   - done holds in DONE until the next accepted start.
//
// Memory contract:
//   - A write issued in cycle k stores the wdata shown in cycle k-1, so
//     mem_wdata always carries the data of the next cycle's op.
//   - Read data returns two cycles after its read is issued.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   start             run request pulse
//   busy, done        run status
//   fail, fail_count  mismatch status of the current run
//   first_fail_*      diagnostics of the first mismatch
//   mem_write_read    1 = write, 0 = read
//   mem_address       memory address
//   mem_wdata         write data, one cycle ahead of its write
//   mem_rdata         memory read data
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [2:0]            first_fail_elem,
  output logic [DATA_WIDTH-1:0] first_fail_data,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] CAP_ADDR = ADDR_WIDTH'(CAPACITY);

  state_t                state, state_nxt;
  elem_t                 elem, elem_nxt, step_elem;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt, step_addr;
  logic                  op, op_nxt, step_op;
  logic                  drain_cnt, drain_nxt;
  logic                  last_op, at_end, last_run, accept;
  logic                  cur_wr, push;
  logic [DATA_WIDTH-1:0] push_data;

  // Position of the op that follows the current one.
  // End of sweep is a compare against the final address, never a wrap.
  always_comb begin
    last_op   = (elem_nops(elem) == 2'd1) || op;
    at_end    = elem_down(elem) ? (addr == '0) : (addr == CAP_ADDR);
    last_run  = (elem == E5) && last_op && at_end;
    step_elem = elem;
    step_addr = addr;
    step_op   = 1'b0;
    if (!last_op) begin
      step_op = 1'b1;
    end else if (!at_end) begin
      step_addr = elem_down(elem) ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
    end else begin
      step_elem = elem_t'(elem + 3'd1);
      step_addr = elem_down(step_elem) ? CAP_ADDR : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= E0;
      addr      <= '0;
      op        <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      elem      <= elem_nxt;
      addr      <= addr_nxt;
      op        <= op_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    addr_nxt  = addr;
    op_nxt    = op;
    drain_nxt = drain_cnt;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = PREP;
          accept    = 1'b1;
        end
      end
      PREP: begin
        state_nxt = RUN;
        elem_nxt  = E0;
        addr_nxt  = '0;
        op_nxt    = 1'b0;
      end
      RUN: begin
        if (last_run) begin
          state_nxt = DRAIN;
          drain_nxt = 1'b0;
        end else begin
          elem_nxt = step_elem;
          addr_nxt = step_addr;
          op_nxt   = step_op;
        end
      end
      DRAIN: begin
        drain_nxt = 1'b1;
        if (drain_cnt) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_wr         = op_is_write(elem, op);
    busy           = (state == PREP) || (state == RUN) || (state == DRAIN);
    done           = (state == DONE);
    mem_write_read = (state == RUN) && cur_wr;
    mem_address    = (state == RUN) ? addr : '0;
    mem_wdata      = '0;
    if (state == PREP)
      mem_wdata = {DATA_WIDTH{op_value(E0, 1'b0)}};
    else if ((state == RUN) && !last_run)
      mem_wdata = {DATA_WIDTH{op_value(step_elem, step_op)}};
    // PREP and DRAIN filler reads are never pushed, so their data is ignored.
    push      = (state == RUN) && !cur_wr;
    push_data = {DATA_WIDTH{op_value(elem, op)}};
  end

  mbist_resp_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_resp_cmp (
    .clk             (clk),
    .rst             (rst),
    .clear           (accept),
    .push            (push),
    .push_data       (push_data),
    .push_addr       (addr),
    .push_elem       (elem),
    .rdata           (mem_rdata),
    .fail            (fail),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr),
    .first_fail_elem (first_fail_elem),
    .first_fail_data (first_fail_data)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl.
// It contains a behavioural memory with optional faults and an expected-op
// queue built from the March C- definition. Full runs are driven from a
// vector table. Status outcomes are compared per vector, and a hand-written
// mid-run reset sequence follows. A second controller with CNT_WIDTH=2 reads
// an all-zero memory to exercise counter saturation.
module tb_mbist_march_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, fail;
  logic [15:0] fail_count;
  logic [3:0]  first_fail_addr;
  logic [2:0]  first_fail_elem;
  logic [7:0]  first_fail_data;
  logic        mem_write_read;
  logic [3:0]  mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        busy2, done2, fail2;
  logic [1:0]  fail_count2;
  logic [3:0]  ffa2;
  logic [2:0]  ffe2;
  logic [7:0]  ffd2;
  logic        wr2;
  logic [3:0]  addr2;
  logic [7:0]  wd2;
  logic [7:0]  rdata2;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;   // 0 none, 1 addr4 bit1 fall clears addr5 bit2, 2 addr0 stuck-at-0

  logic [12:0] exp_q[$];  // {wr, addr, data}

  always #5 clk = ~clk;

  mbist_march_ctrl dut (
    .clk (clk), .rst (rst), .start (start), .busy (busy), .done (done),
    .fail (fail), .fail_count (fail_count), .first_fail_addr (first_fail_addr),
    .first_fail_elem (first_fail_elem), .first_fail_data (first_fail_data),
    .mem_write_read (mem_write_read), .mem_address (mem_address),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
  );

  mbist_march_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .clk (clk), .rst (rst), .start (start), .busy (busy2), .done (done2),
    .fail (fail2), .fail_count (fail_count2), .first_fail_addr (ffa2),
    .first_fail_elem (ffe2), .first_fail_data (ffd2),
    .mem_write_read (wr2), .mem_address (addr2),
    .mem_wdata (wd2), .mem_rdata (rdata2)
  );

  assign rdata2 = 8'h00;

  // Memory model honouring the write-data-one-cycle-early and read-latency-2 contract.
  logic [7:0] mem [16];
  logic [7:0] wd_prev, rd1, rd2;

  always @(posedge clk) begin
    wd_prev <= mem_wdata;
    rd2     <= rd1;
    if (mem_write_read) begin
      mem[mem_address] <= wd_prev;
      if (fault_mode == 1 && mem_address == 4'd4 && mem[4][1] && !wd_prev[1])
        mem[5][2] <= 1'b0;
    end else begin
      rd1 <= (fault_mode == 2 && mem_address == 4'd0) ? 8'h00 : mem[mem_address];
    end
  end

  assign mem_rdata = rd2;

  logic [46:0] outs_all;
  assign outs_all = {busy, done, fail, fail_count, first_fail_addr, first_fail_elem,
                     first_fail_data, mem_write_read, mem_address, mem_wdata};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_op(input logic wr, input logic [3:0] a, input logic bitv);
    exp_q.push_back({wr, a, bitv ? 8'hFF : 8'h00});
  endtask

  // Expected op stream straight from the element list.
  task automatic build_exp();
    logic [3:0] a;
    exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 16; i++) begin
        a = (e == 3 || e == 4) ? 4'(15 - i) : 4'(i);
        case (e)
          0: push_op(1'b1, a, 1'b0);
          1: begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b1); end
          2: begin push_op(1'b0, a, 1'b1); push_op(1'b1, a, 1'b0); end
          3: begin push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b1); end
          4: begin push_op(1'b0, a, 1'b1); push_op(1'b1, a, 1'b0); end
          default: push_op(1'b0, a, 1'b0);
        endcase
      end
    end
  endtask

  // One full run: start edge E, PREP, 160 ops, 2 drain cycles, done at E+163.
  // glitch_at >= 0 pulses start during that RUN op.
  task automatic run_march(input int glitch_at);
    logic [12:0] e;
    logic [7:0]  prev_wd;
    build_exp();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("prep", {busy, done, mem_write_read, mem_wdata}, {3'b100, 8'h00});
    prev_wd = mem_wdata;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      start = (c == glitch_at);
      if (exp_q.size() == 0) begin
        check("op_queue_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("op%0d", c),
              {busy, done, mem_write_read, mem_address, mem_write_read ? prev_wd : 8'h00},
              {2'b10, e[12], e[11:8], e[12] ? e[7:0] : 8'h00});
      end
      prev_wd = mem_wdata;
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("drain%0d", d), {busy, done, mem_write_read}, 3'b100);
    end
    @(negedge clk);
    check("done_latency", {busy, done}, 2'b01);
  endtask

  typedef struct {
    int         fault;
    int         glitch;
    logic       f;
    logic [15:0] cnt;
    logic [3:0] fa;
    logic [2:0] fe;
    logic [7:0] fd;
  } vec_t;

  vec_t vecs[4];

  task automatic do_vector(input vec_t v, input int idx);
    fault_mode = v.fault;
    run_march(v.glitch);
    check($sformatf("v%0d_fail", idx), fail, v.f);
    check($sformatf("v%0d_count", idx), fail_count, v.cnt);
    check($sformatf("v%0d_faddr", idx), first_fail_addr, v.fa);
    check($sformatf("v%0d_felem", idx), first_fail_elem, v.fe);
    check($sformatf("v%0d_fdata", idx), first_fail_data, v.fd);
    check($sformatf("v%0d_sat", idx), {done2, fail2, fail_count2, ffe2, ffa2}, {2'b11, 2'd3, 3'd2, 4'd0});
  endtask

  initial begin
    vecs[0] = '{fault: 0, glitch: -1,  f: 1'b0, cnt: 16'd0, fa: 4'd0, fe: 3'd0, fd: 8'h00};
    vecs[1] = '{fault: 1, glitch: -1,  f: 1'b1, cnt: 16'd1, fa: 4'd5, fe: 3'd2, fd: 8'hFB};
    vecs[2] = '{fault: 2, glitch: 30,  f: 1'b1, cnt: 16'd2, fa: 4'd0, fe: 3'd2, fd: 8'h00};
    vecs[3] = '{fault: 0, glitch: 159, f: 1'b0, cnt: 16'd0, fa: 4'd0, fe: 3'd0, fd: 8'h00};

    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_all, 47'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, done}, 2'b00);

    for (int i = 0; i < 4; i++) do_vector(vecs[i], i);

    // Reset in the middle of E2 of a failing run.
    fault_mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (60) @(negedge clk);
    check("pre_reset_fail", {busy, fail}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrun_reset_outputs", outs_all, 47'd0);
    check("midrun_reset_sat", {busy2, fail2, fail_count2}, 4'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_midrun_reset", {busy, done, fail}, 3'b000);

    do_vector(vecs[0], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
